// File: rtl/ext_obi_rr_arbiter.sv
// ext_obi_rr_arbiter: round-robin arbiter that lets NumMasters OBI masters
// share one external-crossbar OBI slave port. The address phase is arbitrated
// round-robin and held stable once presented. An in-order ID FIFO routes each
// response back to the master that issued the matching request.

package ext_obi_rr_arbiter_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

// Per-master response slice: grant and response steering for one master.
module ext_obi_rr_port
  import ext_obi_rr_arbiter_pkg::*;
#(
  parameter int unsigned IdxW  = 1,
  parameter int unsigned MyIdx = 0
) (
  input  logic            i_hs,
  input  logic [IdxW-1:0] i_sel,
  input  logic            i_rsp_hit,
  input  logic [IdxW-1:0] i_head,
  input  logic [31:0]     i_rdata,
  output obi_resp_t       o_resp
);
  logic w_mine_gnt, w_mine_rsp;

  assign w_mine_gnt = i_hs      && (i_sel  == IdxW'(MyIdx));
  assign w_mine_rsp = i_rsp_hit && (i_head == IdxW'(MyIdx));

  // gnt only for the selected master; rdata is zero unless this master owns the response
  always_comb begin
    o_resp        = '0;
    o_resp.gnt    = w_mine_gnt;
    o_resp.rvalid = w_mine_rsp;
    o_resp.rdata  = w_mine_rsp ? i_rdata : 32'h0;
  end
endmodule

module ext_obi_rr_arbiter
  import ext_obi_rr_arbiter_pkg::*;
#(
  parameter int unsigned NumMasters     = 2,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned IdxW           = $clog2(NumMasters)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  obi_req_t  [NumMasters-1:0] mst_req_i,
  output obi_resp_t [NumMasters-1:0] mst_resp_o,
  output obi_req_t                   slv_req_o,
  input  obi_resp_t                  slv_resp_i,
  output logic                       busy_o,
  output logic                       err_o
);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  // arbitration state
  logic [IdxW-1:0] r_rr_ptr;
  logic            r_lock_valid;
  logic [IdxW-1:0] r_lock_idx;

  // ID FIFO state
  logic [IdxW-1:0] r_fifo [MaxOutstanding];
  logic [PtrW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0] r_count;
  logic            r_err;

  logic [NumMasters-1:0] w_req;
  logic [IdxW-1:0]       w_rot_idx [NumMasters];
  logic [IdxW-1:0]       w_sel_rr, w_sel, w_head;
  logic                  w_full, w_hs, w_push, w_pop, w_stray;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // candidate order: rr_ptr, rr_ptr+1, ... modulo NumMasters
  for (genvar k = 0; k < NumMasters; k++) begin : g_rot
    logic [IdxW:0] w_sum;
    assign w_sum        = {1'b0, r_rr_ptr} + (IdxW+1)'(k);
    assign w_rot_idx[k] = (w_sum >= (IdxW+1)'(NumMasters))
                          ? IdxW'(w_sum - (IdxW+1)'(NumMasters)) : IdxW'(w_sum);
    assign w_req[k]     = mst_req_i[k].req;
  end

  // first requester in rotated order; scanned backwards so the lowest offset wins
  always_comb begin
    w_sel_rr = r_rr_ptr;
    for (int k = NumMasters - 1; k >= 0; k--) begin
      if (w_req[w_rot_idx[k]]) w_sel_rr = w_rot_idx[k];
    end
  end

  assign w_sel  = r_lock_valid ? r_lock_idx : w_sel_rr;
  // registered count only: a same-cycle pop never unblocks, so no rvalid->req path
  assign w_full = (r_count == CntW'(MaxOutstanding));

  // forward the selected master; suppress req while the ID FIFO is full
  always_comb begin
    slv_req_o     = mst_req_i[w_sel];
    slv_req_o.req = mst_req_i[w_sel].req & ~w_full;
  end

  assign w_hs    = slv_req_o.req & slv_resp_i.gnt;
  assign w_push  = w_hs;
  assign w_pop   = slv_resp_i.rvalid & (r_count != '0);
  assign w_stray = slv_resp_i.rvalid & (r_count == '0);
  assign w_head  = r_fifo[r_rd_ptr];

  for (genvar g = 0; g < NumMasters; g++) begin : g_port
    ext_obi_rr_port #(
      .IdxW  (IdxW),
      .MyIdx (g)
    ) u_port (
      .i_hs      (w_hs),
      .i_sel     (w_sel),
      .i_rsp_hit (w_pop),
      .i_head    (w_head),
      .i_rdata   (slv_resp_i.rdata),
      .o_resp    (mst_resp_o[g])
    );
  end

  // round-robin pointer and address-phase lock (held until that master's gnt)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr     <= '0;
      r_lock_valid <= 1'b0;
      r_lock_idx   <= '0;
    end else if (w_hs) begin
      r_rr_ptr     <= (w_sel == IdxW'(NumMasters - 1)) ? '0 : w_sel + IdxW'(1);
      r_lock_valid <= 1'b0;
    end else if (slv_req_o.req) begin
      r_lock_valid <= 1'b1;
      r_lock_idx   <= w_sel;
    end
  end

  // ID FIFO pointers and occupancy; push and pop may coincide
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ID storage; contents are only read while count is non-zero
  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_sel;
  end

  // sticky error on a response with nothing outstanding
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      r_err <= 1'b0;
    else if (w_stray) r_err <= 1'b1;
  end

  assign busy_o = (r_count != '0);
  assign err_o  = r_err;

endmodule
